// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the 16-bit datapath.
// The controller is the master: it reads the current opcode and the memory
// handshake and drives every mux select and write enable.
interface multicycle_ctrl_if;
  logic [3:0] opcode;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic       branch_ne;
  logic       pc_source;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;

  modport master (
    input  opcode, mem_ready,
    output mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
           branch_ne, pc_source, alu_src_a, alu_src_b, alu_ctrl,
           reg_dst, mem_to_reg, reg_write
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
           branch_ne, pc_source, alu_src_a, alu_src_b, alu_ctrl,
           reg_dst, mem_to_reg, reg_write
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle 16-bit MIPS datapath. One instruction
// is sequenced at a time over 3-5 states; memory accesses stretch by one
// state per cycle that mem_ready stays low. State moves on the falling edge
// so it lines up with the datapath registers.
module multicycle_ctrl #(
  parameter int CNT_W           = 16,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_ADDR_I, S_WB_ALU,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_HALT
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_op;        // opcode captured on leaving DECODE
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;    // current state is the last of its instruction

  function automatic logic is_rtype(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_SLT);
  endfunction

  function automatic logic is_itype(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic [2:0] alu_for(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // State, captured opcode and retired counter all advance on the falling edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RESET;
      r_op      <= 4'b0000;
      r_retired <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_DECODE) r_op <= bus.opcode;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Next-state selection and retirement strobe.
  always_comb begin
    w_state_next = r_state;
    w_retire     = 1'b0;
    case (r_state)
      S_RESET:  w_state_next = S_FETCH;
      S_FETCH:  if (bus.mem_ready) w_state_next = S_DECODE;
      S_DECODE: begin
        if (is_rtype(bus.opcode))       w_state_next = S_EXEC_R;
        else if (is_itype(bus.opcode))  w_state_next = S_ADDR_I;
        else if (is_branch(bus.opcode)) w_state_next = S_BRANCH;
        else if (HALT_ON_ILLEGAL)       w_state_next = S_HALT;
        else begin
          // Undefined opcode behaves as a NOP that still counts as retired.
          w_state_next = S_FETCH;
          w_retire     = 1'b1;
        end
      end
      S_EXEC_R: w_state_next = S_WB_ALU;
      S_ADDR_I: begin
        if (r_op == OP_LW)      w_state_next = S_MEM_RD;
        else if (r_op == OP_SW) w_state_next = S_MEM_WR;
        else                    w_state_next = S_WB_ALU;
      end
      S_MEM_RD: if (bus.mem_ready) w_state_next = S_WB_MEM;
      S_MEM_WR: begin
        if (bus.mem_ready) begin
          w_state_next = S_FETCH;
          w_retire     = 1'b1;
        end
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH: begin
        w_state_next = S_FETCH;
        w_retire     = 1'b1;
      end
      S_HALT:   w_state_next = S_HALT;
      default:  w_state_next = S_RESET;
    endcase
  end

  // Control outputs decode from state (and captured opcode); only the FETCH
  // IR/PC loads follow mem_ready so they fire in the completion cycle.
  always_comb begin
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.iord          = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.branch_ne     = 1'b0;
    bus.pc_source     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_ctrl      = ALU_AND;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_write     = 1'b0;
    halted            = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.alu_ctrl  = ALU_ADD;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_b = 2'b11;
        bus.alu_ctrl  = ALU_ADD;
      end
      S_EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_ctrl  = alu_for(r_op);
      end
      S_ADDR_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_ctrl  = ALU_ADD;
      end
      S_WB_ALU: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = is_rtype(r_op);
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      S_WB_MEM: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_ctrl      = ALU_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 1'b1;
        bus.branch_ne     = r_op[0];
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl. Two instances run side by side: lane 0 uses the
// default parameters (16-bit counter, halt on illegal opcode), lane 1 uses a
// 4-bit counter and treats illegal opcodes as NOPs. A reference model expands
// each instruction into its expected per-cycle control words from the
// instruction's phase list, queuing the inputs to drive and the outputs to
// expect; a driver and a monitor consume those queues one cycle at a time.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       mr, mw, iord, irw, pcw, pcc, bne, psrc, sa;
    logic [1:0] sb;
    logic [2:0] alu;
    logic       rd, m2r, rw;
  } ctl_t;

  typedef struct packed {
    logic       rst_n;
    logic       mem_ready;
    logic [3:0] opcode;
  } stim_t;

  typedef struct packed {
    ctl_t        ctl;
    logic        halted;
    logic [15:0] retired;
  } exp_t;

  logic       clk;
  logic       rst_n_a, rst_n_b;
  logic       halted_a, halted_b;
  logic [15:0] retired_a;
  logic [3:0]  retired_b;

  multicycle_ctrl_if bus_a();
  multicycle_ctrl_if bus_b();

  multicycle_ctrl #(.CNT_W(16), .HALT_ON_ILLEGAL(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .bus(bus_a), .halted(halted_a), .retired(retired_a)
  );

  multicycle_ctrl #(.CNT_W(4), .HALT_ON_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .bus(bus_b), .halted(halted_b), .retired(retired_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  stim_t stim_a[$], stim_b[$];
  exp_t  exp_a[$],  exp_b[$];
  int    cnt[2];        // model: instructions retired since reset
  bit    hlt[2];        // model: lane has halted
  int    n_total = 0;
  int    n_pass  = 0;
  logic [3:0] legal[10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9};

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom_range(0, 15));
  endfunction

  // ---------------- phase control words, straight from the state table ----------------
  function automatic ctl_t k_fetch(input logic done);
    ctl_t c = '0;
    c.mr = 1'b1; c.sb = 2'b01; c.alu = 3'b010; c.irw = done; c.pcw = done;
    return c;
  endfunction

  function automatic ctl_t k_decode();
    ctl_t c = '0;
    c.sb = 2'b11; c.alu = 3'b010;
    return c;
  endfunction

  function automatic ctl_t k_exec(input logic [3:0] op);
    ctl_t c = '0;
    c.sa = 1'b1;
    case (op)
      4'h0:    c.alu = 3'b010;
      4'h1:    c.alu = 3'b110;
      4'h2:    c.alu = 3'b000;
      4'h3:    c.alu = 3'b001;
      default: c.alu = 3'b111;
    endcase
    return c;
  endfunction

  function automatic ctl_t k_addr();
    ctl_t c = '0;
    c.sa = 1'b1; c.sb = 2'b10; c.alu = 3'b010;
    return c;
  endfunction

  function automatic ctl_t k_wb(input logic from_mem, input logic to_rd);
    ctl_t c = '0;
    c.rw = 1'b1; c.m2r = from_mem; c.rd = to_rd;
    return c;
  endfunction

  function automatic ctl_t k_mem(input logic write);
    ctl_t c = '0;
    c.mr = !write; c.mw = write; c.iord = 1'b1;
    return c;
  endfunction

  function automatic ctl_t k_branch(input logic ne);
    ctl_t c = '0;
    c.sa = 1'b1; c.alu = 3'b110; c.pcc = 1'b1; c.psrc = 1'b1; c.bne = ne;
    return c;
  endfunction

  // ---------------- reference model ----------------
  task automatic push(input int lane, input logic rst, input logic rdy,
                      input logic [3:0] op, input ctl_t c, input logic h);
    stim_t s;
    exp_t  e;
    s.rst_n = rst; s.mem_ready = rdy; s.opcode = op;
    e.ctl = c; e.halted = h;
    e.retired = 16'(cnt[lane] % ((lane == 0) ? 65536 : 16));
    if (lane == 0) begin stim_a.push_back(s); exp_a.push_back(e); end
    else           begin stim_b.push_back(s); exp_b.push_back(e); end
  endtask

  task automatic do_reset(input int lane);
    cnt[lane] = 0;
    hlt[lane] = 1'b0;
    push(lane, 1'b0, rbit(), rop(), '0, 1'b0);
    push(lane, 1'b1, rbit(), rop(), '0, 1'b0);  // RESET state, one cycle
  endtask

  // One instruction: fw wait cycles in fetch, mw wait cycles on a data access.
  task automatic issue(input int lane, input logic [3:0] op, input int fw, input int mw);
    if (hlt[lane]) begin
      repeat (3) push(lane, 1'b1, rbit(), rop(), '0, 1'b1);
      return;
    end
    for (int i = 0; i < fw; i++) push(lane, 1'b1, 1'b0, rop(), k_fetch(1'b0), 1'b0);
    push(lane, 1'b1, 1'b1, rop(), k_fetch(1'b1), 1'b0);
    push(lane, 1'b1, rbit(), op, k_decode(), 1'b0);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h7: begin
        push(lane, 1'b1, rbit(), rop(), k_exec(op), 1'b0);
        push(lane, 1'b1, rbit(), rop(), k_wb(1'b0, 1'b1), 1'b0);
        cnt[lane]++;
      end
      4'h4: begin
        push(lane, 1'b1, rbit(), rop(), k_addr(), 1'b0);
        push(lane, 1'b1, rbit(), rop(), k_wb(1'b0, 1'b0), 1'b0);
        cnt[lane]++;
      end
      4'h5, 4'h6: begin
        push(lane, 1'b1, rbit(), rop(), k_addr(), 1'b0);
        for (int i = 0; i < mw; i++) push(lane, 1'b1, 1'b0, rop(), k_mem(op[1]), 1'b0);
        push(lane, 1'b1, 1'b1, rop(), k_mem(op[1]), 1'b0);
        if (op == 4'h5) push(lane, 1'b1, rbit(), rop(), k_wb(1'b1, 1'b0), 1'b0);
        cnt[lane]++;
      end
      4'h8, 4'h9: begin
        push(lane, 1'b1, rbit(), rop(), k_branch(op[0]), 1'b0);
        cnt[lane]++;
      end
      default: begin
        if (lane == 0) begin
          hlt[lane] = 1'b1;
          repeat (4) push(lane, 1'b1, rbit(), rop(), '0, 1'b1);
        end else begin
          cnt[lane]++;
        end
      end
    endcase
  endtask

  // ADD instruction interrupted by reset while in EXEC_R.
  task automatic abort_in_exec(input int lane);
    push(lane, 1'b1, 1'b1, rop(), k_fetch(1'b1), 1'b0);
    push(lane, 1'b1, rbit(), 4'h0, k_decode(), 1'b0);
    do_reset(lane);
  endtask

  // ---------------- checking ----------------
  task automatic check(input int lane, input exp_t e, input ctl_t c,
                       input logic h, input logic [15:0] r);
    n_total++;
    if (c === e.ctl) n_pass++;
    else $display("FAIL lane%0d ctl @%0t: got %05h required %05h", lane, $time, c, e.ctl);
    n_total++;
    if (h === e.halted) n_pass++;
    else $display("FAIL lane%0d halted @%0t: got %0b required %0b", lane, $time, h, e.halted);
    n_total++;
    if (r === e.retired) n_pass++;
    else $display("FAIL lane%0d retired @%0t: got %0d required %0d", lane, $time, r, e.retired);
  endtask

  // Driver: applies one queued input set per cycle, just after the rising edge.
  initial begin
    stim_t s;
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    bus_a.opcode = 4'h0; bus_a.mem_ready = 1'b0;
    bus_b.opcode = 4'h0; bus_b.mem_ready = 1'b0;
    #1;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stim_a.size() > 0) begin
        s = stim_a.pop_front();
        rst_n_a = s.rst_n; bus_a.mem_ready = s.mem_ready; bus_a.opcode = s.opcode;
      end
      if (stim_b.size() > 0) begin
        s = stim_b.pop_front();
        rst_n_b = s.rst_n; bus_b.mem_ready = s.mem_ready; bus_b.opcode = s.opcode;
      end
    end
  end

  // Monitor: compares outputs mid-cycle, well before the falling (active) edge.
  initial begin
    exp_t e;
    ctl_t c;
    forever begin
      @(posedge clk);
      #3;
      if (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        c = {bus_a.mem_read, bus_a.mem_write, bus_a.iord, bus_a.ir_write, bus_a.pc_write,
             bus_a.pc_write_cond, bus_a.branch_ne, bus_a.pc_source, bus_a.alu_src_a,
             bus_a.alu_src_b, bus_a.alu_ctrl, bus_a.reg_dst, bus_a.mem_to_reg, bus_a.reg_write};
        check(0, e, c, halted_a, retired_a);
      end
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        c = {bus_b.mem_read, bus_b.mem_write, bus_b.iord, bus_b.ir_write, bus_b.pc_write,
             bus_b.pc_write_cond, bus_b.branch_ne, bus_b.pc_source, bus_b.alu_src_a,
             bus_b.alu_src_b, bus_b.alu_ctrl, bus_b.reg_dst, bus_b.mem_to_reg, bus_b.reg_write};
        check(1, e, c, halted_b, {12'd0, retired_b});
      end
    end
  end

  // Stimulus plan, then wait for both lanes to drain.
  initial begin
    for (int l = 0; l < 2; l++) begin
      do_reset(l);
      issue(l, 4'h4, 0, 0);            // ADDI
      issue(l, 4'h0, 0, 0);            // ADD
      issue(l, 4'h5, 0, 0);            // LW
      issue(l, 4'h6, 0, 0);            // SW
      issue(l, 4'h8, 0, 0);            // BEQ
      issue(l, 4'h5, 0, 3);            // LW, three wait cycles on the read
      issue(l, 4'h9, 0, 0);            // BNE
      issue(l, 4'h8, 1, 0);            // BEQ with a fetch wait
      issue(l, 4'h6, 2, 1);            // SW with fetch and write waits
      repeat (40) issue(l, legal[$urandom_range(0, 9)], $urandom_range(0, 2), $urandom_range(0, 2));
      abort_in_exec(l);
      repeat (16) issue(l, 4'h0, 0, 0);  // 4-bit lane wraps back to 0
      issue(l, 4'hF, 0, 0);            // illegal: lane 0 halts, lane 1 NOP
      issue(l, 4'hA, 0, 0);
      issue(l, 4'hC, 1, 0);
      issue(l, 4'h0, 0, 0);
      issue(l, 4'h5, 0, 1);
    end
    for (int c = 0; c < 20000 && (exp_a.size() > 0 || exp_b.size() > 0); c++) @(posedge clk);
    if (exp_a.size() > 0 || exp_b.size() > 0) begin
      n_total++;
      $display("FAIL drain: got %0d/%0d entries left, required 0/0", exp_a.size(), exp_b.size());
    end
    repeat (2) @(posedge clk);
    #5;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
